// File: rtl/flit_sink_pkg.sv
// flit_sink shared types: flit type encodings, widths and FSM states.
// Imported by the sink top and its popcount helper.
package flit_sink_pkg;

  localparam int DATA_W = 66;
  localparam int TYPE_W = 2;
  localparam int VCH_W  = 1;

  localparam logic [TYPE_W-1:0] TYPE_NONE = 2'b00;
  localparam logic [TYPE_W-1:0] TYPE_HEAD = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_TAIL = 2'b10;
  localparam logic [TYPE_W-1:0] TYPE_DATA = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

endpackage

// File: rtl/flit_sink_popcount.sv
// flit_sink_popcount: combinational population count.
// Result width is $clog2(W+1) bits.
module flit_sink_popcount #(
  parameter int W = 66
) (
  input  logic [W-1:0]              vec,
  output logic [$clog2(W+1)-1:0]    cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + {{($clog2(W+1)-1){1'b0}}, vec[i]};
    end
  end

endmodule

// File: rtl/flit_sink.sv
// flit_sink: receive endpoint for the flit mux output.
// Reassembles packets, flags protocol errors, counts link activity.
module flit_sink
  import flit_sink_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata,
  input  logic              ivalid,
  input  logic [VCH_W-1:0]  ivch,
  input  logic              en,
  input  logic              clr,
  output logic              busy,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  last_len,
  output logic [31:0]       last_dst,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  flit_cnt,
  output logic [CNT_W-1:0]  toggle_cnt,
  output logic [2:0]        err
);

  localparam int PC_W = $clog2(DATA_W+1);

  state_t             state;
  logic [DATA_W-1:0]  prev_data;
  logic [VCH_W-1:0]   cap_vch;
  logic [31:0]        cap_dst;
  logic [LEN_W-1:0]   pkt_len;

  logic [TYPE_W-1:0]  typ;
  logic [LEN_W-1:0]   len_inc;
  logic [PC_W-1:0]    pc;
  logic [CNT_W:0]     tsum;
  logic               in_body;
  logic               orphan;
  logic               head_err;
  logic               vch_err;
  logic               accept;
  logic               done;

  flit_sink_popcount #(.W(DATA_W)) u_pop (
    .vec (idata ^ prev_data),
    .cnt (pc)
  );

  assign typ      = idata[DATA_W-1 -: TYPE_W];
  assign in_body  = (state == BODY);
  assign busy     = in_body;
  assign orphan   = ivalid && !in_body &&
                    (typ == TYPE_TAIL || typ == TYPE_DATA);
  assign head_err = ivalid && in_body && (typ == TYPE_HEAD);
  assign vch_err  = ivalid && in_body && (ivch != cap_vch);
  assign accept   = ivalid && (typ != TYPE_NONE) && !orphan;
  assign done     = ivalid && in_body && (typ == TYPE_TAIL);
  assign len_inc  = (pkt_len == {LEN_W{1'b1}}) ? pkt_len
                                               : pkt_len + 1'b1;
  assign tsum     = {1'b0, toggle_cnt} + (CNT_W+1)'(pc);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      prev_data <= '0;
      cap_vch   <= '0;
      cap_dst   <= '0;
      pkt_len   <= '0;
      pkt_done  <= 1'b0;
      last_len  <= '0;
      last_dst  <= '0;
    end else begin
      prev_data <= idata;
      pkt_done  <= 1'b0;
      if (ivalid) begin
        unique case (state)
          IDLE: begin
            if (typ == TYPE_HEAD) begin
              state   <= BODY;
              cap_vch <= ivch;
              cap_dst <= idata[31:0];
              pkt_len <= LEN_W'(1);
            end
          end
          BODY: begin
            unique case (typ)
              TYPE_HEAD: begin
                cap_vch <= ivch;
                cap_dst <= idata[31:0];
                pkt_len <= LEN_W'(1);
              end
              TYPE_DATA: pkt_len <= len_inc;
              TYPE_TAIL: begin
                last_len <= len_inc;
                last_dst <= cap_dst;
                pkt_done <= 1'b1;
                state    <= IDLE;
              end
              default: ;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // clr overrides any same-cycle increment or error set
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pkt_cnt    <= '0;
      flit_cnt   <= '0;
      toggle_cnt <= '0;
      err        <= '0;
    end else if (clr) begin
      pkt_cnt    <= '0;
      flit_cnt   <= '0;
      toggle_cnt <= '0;
      err        <= '0;
    end else begin
      err <= err | {vch_err, head_err, orphan};
      if (en) begin
        if (done && pkt_cnt != {CNT_W{1'b1}})
          pkt_cnt <= pkt_cnt + 1'b1;
        if (accept && flit_cnt != {CNT_W{1'b1}})
          flit_cnt <= flit_cnt + 1'b1;
        toggle_cnt <= tsum[CNT_W] ? {CNT_W{1'b1}}
                                  : tsum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_flit_sink.sv
// tb_flit_sink: directed and random checks of flit_sink
// against a packet-level reference model.
module tb_flit_sink;

  localparam longint CMAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [65:0] idata = '0;
  logic        ivalid = 1'b0;
  logic [0:0]  ivch = '0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        busy;
  logic        pkt_done;
  logic [7:0]  last_len;
  logic [31:0] last_dst;
  logic [31:0] pkt_cnt;
  logic [31:0] flit_cnt;
  logic [31:0] toggle_cnt;
  logic [2:0]  err;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit          m_in;
  int          m_len;
  bit          m_vch;
  logic [31:0] m_dst;
  int          m_last_len;
  logic [31:0] m_last_dst;
  bit          m_done;
  longint      m_pkt, m_flit, m_tog;
  logic [2:0]  m_err;
  logic [65:0] m_prev;

  flit_sink dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid),
    .ivch(ivch), .en(en), .clr(clr), .busy(busy),
    .pkt_done(pkt_done), .last_len(last_len),
    .last_dst(last_dst), .pkt_cnt(pkt_cnt),
    .flit_cnt(flit_cnt), .toggle_cnt(toggle_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_in = 0; m_len = 0; m_vch = 0; m_dst = '0;
    m_last_len = 0; m_last_dst = '0; m_done = 0;
    m_pkt = 0; m_flit = 0; m_tog = 0;
    m_err = '0; m_prev = '0;
  endtask

  function automatic longint sat(input longint v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic m_edge();
    logic [1:0] t;
    bit done_now, counted;
    t = idata[65:64];
    done_now = 0;
    counted = ivalid && t != 2'b00 && (m_in || t == 2'b01);
    if (ivalid) begin
      if (!m_in && (t == 2'b10 || t == 2'b11)) m_err[0] = 1'b1;
      if (m_in && t == 2'b01) m_err[1] = 1'b1;
      if (m_in && ivch[0] != m_vch) m_err[2] = 1'b1;
    end
    if (ivalid && t == 2'b01) begin
      m_in = 1; m_len = 1; m_vch = ivch[0]; m_dst = idata[31:0];
    end else if (ivalid && m_in && t == 2'b11) begin
      m_len = (m_len + 1 > 255) ? 255 : m_len + 1;
    end else if (ivalid && m_in && t == 2'b10) begin
      m_last_len = (m_len + 1 > 255) ? 255 : m_len + 1;
      m_last_dst = m_dst;
      m_in = 0;
      done_now = 1;
    end
    m_done = done_now;
    if (clr) begin
      m_pkt = 0; m_flit = 0; m_tog = 0; m_err = '0;
    end else if (en) begin
      m_pkt  = sat(m_pkt + longint'(done_now));
      m_flit = sat(m_flit + longint'(counted));
      m_tog  = sat(m_tog + longint'($countones(idata ^ m_prev)));
    end
    m_prev = idata;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"}, longint'(busy), longint'(m_in));
    chk({tag, ".done"}, longint'(pkt_done), longint'(m_done));
    chk({tag, ".len"}, longint'(last_len), longint'(m_last_len));
    chk({tag, ".dst"}, longint'(last_dst), longint'(m_last_dst));
    chk({tag, ".pkt"}, longint'(pkt_cnt), m_pkt);
    chk({tag, ".flit"}, longint'(flit_cnt), m_flit);
    chk({tag, ".tog"}, longint'(toggle_cnt), m_tog);
    chk({tag, ".err"}, longint'(err), longint'(m_err));
  endtask

  task automatic step(input logic [65:0] d, input bit v,
                      input bit vc, input bit e, input bit c,
                      input string tag);
    @(negedge clk);
    idata = d; ivalid = v; ivch = vc; en = e; clr = c;
    @(posedge clk);
    m_edge();
    #1;
    check_all(tag);
  endtask

  function automatic logic [65:0] fl(input logic [1:0] t,
                                     input logic [31:0] dst);
    return {t, 32'h0, dst};
  endfunction

  initial begin
    logic [65:0] ones;
    ones = '1;
    m_reset();

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idata = {$urandom, $urandom, $urandom};
      ivalid = 1'($urandom);
      en = 1'b1;
    end
    #1;
    check_all("rst");
    @(negedge clk);
    idata = '0; ivalid = 0; en = 0;
    rst_ = 1'b1;
    for (int i = 0; i < 3; i++) step('0, 0, 0, 0, 0, "idle");

    // toggle accumulation
    step(ones, 0, 0, 1, 0, "tog");
    step('0, 0, 0, 1, 0, "tog");
    step(ones, 0, 0, 1, 0, "tog");
    step('0, 0, 0, 1, 0, "tog");
    chk("tog264", longint'(toggle_cnt), 264);
    for (int i = 0; i < 4; i++)
      step((i % 2 == 0) ? ones : '0, 0, 0, 0, 0, "tog_off");
    chk("tog_hold", longint'(toggle_cnt), 264);
    step('0, 0, 0, 0, 1, "clr0");

    // full packet with bubbles
    step(fl(2'b01, 32'd9), 1, 0, 1, 0, "pkt");
    for (int i = 0; i < 20; i++) begin
      if (i == 7 || i == 13) step(fl(2'b11, i), 0, 0, 1, 0, "bub");
      step(fl(2'b11, i), 1, 0, 1, 0, "pkt");
    end
    chk("pre_done", longint'(pkt_done), 0);
    step(fl(2'b10, 32'd0), 1, 0, 1, 0, "tail");
    chk("done", longint'(pkt_done), 1);
    chk("len22", longint'(last_len), 22);
    chk("dst9", longint'(last_dst), 9);
    chk("pkt1", longint'(pkt_cnt), 1);
    chk("flit22", longint'(flit_cnt), 22);
    chk("err0", longint'(err), 0);
    step('0, 0, 0, 1, 0, "post");
    chk("done_once", longint'(pkt_done), 0);

    // orphan and clear
    step('0, 0, 0, 1, 1, "clr1");
    step(fl(2'b10, 32'd3), 1, 0, 1, 0, "orph");
    chk("orph_err", longint'(err), 3'b001);
    chk("orph_pkt", longint'(pkt_cnt), 0);
    chk("orph_flit", longint'(flit_cnt), 0);
    step(fl(2'b10, 32'd3), 1, 0, 1, 1, "orphclr");
    chk("clr_err", longint'(err), 0);

    // HEAD inside packet aborts and restarts
    step(fl(2'b01, 32'd4), 1, 0, 1, 0, "abt");
    for (int i = 0; i < 3; i++)
      step(fl(2'b11, i), 1, 0, 1, 0, "abt");
    step(fl(2'b01, 32'd5), 1, 0, 1, 0, "abt");
    step(fl(2'b10, 32'd0), 1, 0, 1, 0, "abt");
    chk("abt_err1", longint'(err[1]), 1);
    chk("abt_pkt", longint'(pkt_cnt), 1);
    chk("abt_len", longint'(last_len), 2);
    chk("abt_dst", longint'(last_dst), 5);

    // vch change then async reset mid-packet
    step('0, 0, 0, 1, 1, "clr2");
    step(fl(2'b01, 32'd7), 1, 0, 1, 0, "vch");
    step(fl(2'b11, 32'd1), 1, 1, 1, 0, "vch");
    chk("vch_err2", longint'(err[2]), 1);
    chk("vch_busy", longint'(busy), 1);
    #2 rst_ = 1'b0;
    #1;
    m_reset();
    chk("arst_busy", longint'(busy), 0);
    chk("arst_err", longint'(err), 0);
    chk("arst_done", longint'(pkt_done), 0);
    @(negedge clk);
    idata = '0; ivalid = 0;
    rst_ = 1'b1;
    step('0, 0, 0, 1, 0, "arst_post");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [65:0] d;
      d = {$urandom, $urandom, $urandom};
      step(d, $urandom_range(3) != 0,
           $urandom_range(9) == 0,
           $urandom_range(9) != 0,
           $urandom_range(39) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flit_sink.md
Name: flit_sink

Overview:
- Receive-side endpoint for the 2:1 flit mux output (`odata`/`ovalid`/`ovch`) in the mux energy-characterization flow.
- Parses HEAD/DATA/TAIL flits, reassembles packet boundaries and checks flit-protocol legality.
- Accumulates packet, flit and bus-toggle statistics, so benches and synthesized harnesses can measure link activity and switching without post-processing VCD.

Parameters:
- DATA_W, 66, flit width including type field.
- TYPE_W, 2, type field width; occupies the top bits idata[DATA_W-1 -: TYPE_W].
- VCH_W, 1, virtual-channel id width.
- CNT_W, 32, width of all statistics counters.
- LEN_W, 8, width of the packet-length register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  asynchronous reset, active-low.
- idata  in  DATA_W  flit from mux `odata`.
- ivalid  in  1  flit valid from mux `ovalid`.
- ivch  in  VCH_W  virtual channel from mux `ovch`.
- en  in  1  statistics enable; counters advance only when 1.
- clr  in  1  synchronous clear of counters and error flags.
- busy  out  1  1 while inside a packet (state BODY).
- pkt_done  out  1  one-cycle pulse on packet completion.
- last_len  out  LEN_W  flit count of last completed packet, including HEAD and TAIL.
- last_dst  out  32  idata[31:0] captured from the HEAD of last completed packet.
- pkt_cnt  out  CNT_W  completed packets.
- flit_cnt  out  CNT_W  accepted valid flits.
- toggle_cnt  out  CNT_W  accumulated Hamming distance between consecutive idata samples.
- err  out  3  sticky errors: [0] orphan DATA/TAIL, [1] HEAD inside packet, [2] vch change mid-packet.

Behaviour:
- Reset (rst_=0, asynchronous):
  - State IDLE.
  - All outputs 0; prev_data 0; pkt_len 0; captured vch/dst 0.
  - Reset asserted mid-packet aborts the packet with no pkt_done.
- Type encoding: NONE=2'b00, HEAD=2'b01, TAIL=2'b10, DATA=2'b11.
- Flit sampling: a flit is sampled on each rising edge with ivalid=1. ivalid=0 cycles are bubbles; they are legal anywhere and change no state.
- FSM, state IDLE:
  - HEAD: enter BODY; capture vch and dst; pkt_len=1.
  - DATA or TAIL: set err[0]; flit dropped; stay IDLE.
  - NONE: ignored.
- FSM, state BODY:
  - DATA: pkt_len+1.
  - TAIL: last_len=pkt_len+1; last_dst=captured dst; pkt_done=1 for the next cycle; pkt_cnt+1 (if en); go IDLE.
  - HEAD: set err[1]; abort the current packet with no pkt_done; restart with the new HEAD (pkt_len=1, recapture vch/dst).
  - NONE: ignored.
  - Any valid flit with ivch differing from the captured vch: set err[2]; the flit is still processed by type.
- pkt_len: saturates at 2^LEN_W-1.
- Latency: pkt_done, last_len and last_dst update on the edge that samples TAIL, so they are visible the cycle after TAIL is presented. No back-to-back restriction: TAIL followed immediately by HEAD is legal.
- flit_cnt: +1 per valid non-NONE flit accepted by the FSM when en=1. Orphans are not counted.
- toggle_cnt:
  - Every cycle with en=1, add popcount(idata ^ prev_data), regardless of ivalid.
  - prev_data <= idata every cycle, whatever the value of en.
  - One-cycle latency.
- Counters saturate at all-ones; they never wrap.
- clr: synchronous; zeroes pkt_cnt, flit_cnt, toggle_cnt and err. Does not affect FSM, prev_data, last_len or last_dst. clr in the same cycle as an increment gives 0 (clr wins).
- err bits: sticky until clr or reset. A simultaneous set and clr gives 0.

Decomposition:
- Shared define/package file holds TYPE_NONE/HEAD/TAIL/DATA encodings, TYPE_W, DATA_W, VCH_W and the state encodings (IDLE=1'b0, BODY=1'b1).
- One sub-module: popcount, a parameterized-width combinational population count returning $clog2(DATA_W+1) bits. It is instantiated once on idata ^ prev_data.

Test Plan:
- Reset: hold rst_=0 with random idata/ivalid -> all outputs 0. Release, wait 3 idle cycles -> still 0.
- Packet: en=1; HEAD{01,0,9}, 20 DATA, TAIL on vch 0, with ivalid=0 for 2 bubbles mid-packet -> pkt_done high exactly 1 cycle after TAIL; last_len=22, last_dst=9, pkt_cnt=1, flit_cnt=22, err=0.
- Toggle: en=1 from reset; idata sequence all-ones, 0, all-ones, 0 with ivalid=0 -> toggle_cnt=264. Then en=0 for 4 more alternations -> toggle_cnt stays 264.
- Orphan/clr: TAIL while IDLE -> err=3'b001, pkt_cnt=0, flit_cnt=0. Pulse clr together with a valid TAIL -> err=0 the next cycle.
- Abort: HEAD(dst 4), 3 DATA, HEAD(dst 5), TAIL -> err[1]=1, pkt_cnt=1, last_len=2, last_dst=5.
- Vch/reset: HEAD vch 0, DATA vch 1 -> err[2]=1, busy=1. Assert rst_ mid-packet -> busy=0 and err=0 immediately, asynchronously, with no pkt_done.
